sramlike_data_responder: RTL and testbench

Responder end of the data-side SRAM-like interface driven by the EXE stage: accepts `data_sram_req` with an `addr_ok` handshake and returns in-order `data_ok`/`rdata` after a programmable latency. It is backed by an internal word-addressed byte-writable memory. It serves as the data-memory model for pipeline bring-up and as the reference slave for verifying the issue side before the dcache/AXI bridge is attached. Up to `QDEPTH` requests may be outstanding.

---
 rtl/sramlike_data_responder_if.sv | 30 +++
 rtl/sramlike_data_responder.sv | 93 +++++++++
 tb/tb_sramlike_data_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sramlike_data_responder_if.sv
// Data-side SRAM-like request/response bundle between the EXE-stage
// requester (master) and the data-memory responder (slave).
//
// Handshake: a request transfers on a rising edge where data_sram_req and
// data_sram_addr_ok are both high; addr_ok never depends on req. Every
// accepted request later produces exactly one single-cycle data_ok pulse,
// in acceptance order, with rdata valid only in that cycle.
interface sramlike_data_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size,
               data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size,
               data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/sramlike_data_responder.sv
// Data-memory responder: word-addressed byte-writable memory behind an
// in-order response queue of QDEPTH entries, each answering LATENCY cycles
// after acceptance (or one cycle after the previous response if later).
module sramlike_data_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    sramlike_data_responder_if.slave bus,
    output logic [31:0] resp_cnt
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   mem [2**ADDR_W];

    logic          q_valid [QDEPTH];
    logic          q_wr    [QDEPTH];
    logic [31:0]   q_data  [QDEPTH];
    logic [3:0]    q_cnt   [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic              accept;
    logic              pop;
    logic [ADDR_W-1:0] idx;

    // Size and the bits outside the word index carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr};

    assign idx    = bus.data_sram_addr[ADDR_W+1:2];
    assign accept = bus.data_sram_req & bus.data_sram_addr_ok;
    assign pop    = bus.data_sram_data_ok;

    // Accept/response outputs are decoded purely from registered queue state.
    assign bus.data_sram_addr_ok = (count < CW'(QDEPTH));
    assign bus.data_sram_data_ok = q_valid[head] && (q_cnt[head] == 4'd0);
    assign bus.data_sram_rdata   = (bus.data_sram_data_ok && !q_wr[head]) ? q_data[head] : 32'h0;

    // Byte-lane memory update on write accepts; contents survive reset.
    always_ff @(posedge clk) begin
        if (resetn && accept && bus.data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response queue: countdown, pop at head, push at tail, pointer/count upkeep.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_valid[i] <= 1'b0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            resp_cnt <= 32'h0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (q_valid[i] && (q_cnt[i] != 4'd0)) begin
                    q_cnt[i] <= q_cnt[i] - 4'd1;
                end
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= (head == PW'(QDEPTH - 1)) ? '0 : head + PW'(1);
                resp_cnt      <= resp_cnt + 32'd1;
            end
            // The tail slot is always free when accepting, so it never
            // collides with the head being popped in the same cycle.
            if (accept) begin
                q_valid[tail] <= 1'b1;
                q_wr[tail]    <= bus.data_sram_wr;
                // mem is read before the same-edge write lands.
                q_data[tail]  <= bus.data_sram_wr ? 32'h0 : mem[idx];
                q_cnt[tail]   <= 4'(LATENCY - 1);
                tail          <= (tail == PW'(QDEPTH - 1)) ? '0 : tail + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sramlike_data_responder.sv
// Bench for sramlike_data_responder: three instances (LATENCY 2, 4, 1; all
// QDEPTH 2) share one stimulus bus, with req steered to the selected one.
module tb_sramlike_data_responder;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          sel = 0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        addr_ok_v [3];
    logic        data_ok_v [3];
    logic [31:0] rdata_v   [3];
    logic [31:0] resp_cnt_v[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        sramlike_data_responder_if bus ();
        assign bus.data_sram_req   = req && (sel == g);
        assign bus.data_sram_wr    = wr;
        assign bus.data_sram_size  = size;
        assign bus.data_sram_wstrb = wstrb;
        assign bus.data_sram_addr  = addr;
        assign bus.data_sram_wdata = wdata;
        assign addr_ok_v[g] = bus.data_sram_addr_ok;
        assign data_ok_v[g] = bus.data_sram_data_ok;
        assign rdata_v[g]   = bus.data_sram_rdata;
        sramlike_data_responder #(.ADDR_W(10), .LATENCY(LAT), .QDEPTH(QD)) u_dut (
            .clk(clk),
            .resetn(resetn),
            .bus(bus),
            .resp_cnt(resp_cnt_v[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 4 : 1);
    endfunction

    // Reference model: a list of pending responses, each stamped with the
    // cycle it must complete in, plus a word array per instance.
    typedef struct {
        int          t;
        logic        wr;
        logic [31:0] d;
    } resp_t;

    resp_t       mq[$];
    logic [31:0] mem_m [3][1024];
    logic [31:0] exp_cnt [3];
    int          last_t = 0;
    logic        chk_en = 1'b0;
    logic [31:0] rd_seen = 32'h0;

    // Per-cycle compare of the selected instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        ea;
            logic        ed;
            logic [31:0] er;
            int          idx;
            int          t_own;
            resp_t       e;
            ea = (mq.size() < QD);
            ed = (mq.size() != 0) && (mq[0].t == cyc);
            er = (ed && !mq[0].wr) ? mq[0].d : 32'h0;
            check("addr_ok", {31'b0, addr_ok_v[sel]}, {31'b0, ea});
            check("data_ok", {31'b0, data_ok_v[sel]}, {31'b0, ed});
            check("rdata", rdata_v[sel], er);
            check("resp_cnt", resp_cnt_v[sel], exp_cnt[sel]);
            if (ed) begin
                if (!mq[0].wr) rd_seen = rdata_v[sel];
                void'(mq.pop_front());
                exp_cnt[sel] = exp_cnt[sel] + 32'd1;
            end
            if (!resetn) begin
                mq.delete();
                for (int i = 0; i < 3; i++) exp_cnt[i] = 32'h0;
                last_t = 0;
            end else if (req && ea) begin
                idx   = int'(addr[11:2]);
                t_own = cyc + lat_of(sel);
                e.t   = (t_own > last_t + 1) ? t_own : last_t + 1;
                e.wr  = wr;
                e.d   = wr ? 32'h0 : mem_m[sel][idx];
                last_t = e.t;
                mq.push_back(e);
                if (wr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wstrb[i]) mem_m[sel][idx][8*i +: 8] = wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req = r; wr = w; wstrb = s; addr = a; wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Hold a request until it is accepted, bounded.
    task automatic issue(input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        bit done = 0;
        drive(1'b1, w, s, a, d);
        for (int k = 0; k < 50 && !done; k++) begin
            if (addr_ok_v[sel]) done = 1;
            step();
        end
        if (!done) check("issue_timeout", 32'd1, 32'd0);
        idle();
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (mq.size() == 0) done = 1;
            else step();
        end
        if (!done) check("drain_timeout", 32'd1, 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [6:0] ao;
    logic [6:0] dk;

    initial begin
        for (int i = 0; i < 3; i++) exp_cnt[i] = 32'h0;
        // Reset and post-reset outputs.
        step(); chk_en = 1'b1; step(); step();
        resetn = 1'b1;
        step();
        check("rst_addr_ok", {31'b0, addr_ok_v[0]}, 32'd1);
        check("rst_data_ok", {31'b0, data_ok_v[0]}, 32'd0);
        check("rst_rdata", rdata_v[0], 32'h0);
        check("rst_resp_cnt", resp_cnt_v[0], 32'h0);

        // Write then read, LATENCY=2.
        sel = 0;
        drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h11223344); step();
        drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0); step();
        idle();
        check("wr_rd_dok2", {31'b0, data_ok_v[0]}, 32'd1);
        check("wr_rd_rdata2", rdata_v[0], 32'h0);
        step();
        check("wr_rd_dok3", {31'b0, data_ok_v[0]}, 32'd1);
        check("wr_rd_rdata3", rdata_v[0], 32'h11223344);
        step();
        check("wr_rd_dok4", {31'b0, data_ok_v[0]}, 32'd0);
        check("wr_rd_cnt", resp_cnt_v[0], 32'd2);

        // Byte and half strobes.
        rd_seen = 32'h0;
        issue(1'b1, 4'h2, 32'h40, 32'hAAAAAAAA);
        issue(1'b1, 4'hC, 32'h40, 32'hBBBBBBBB);
        issue(1'b0, 4'h0, 32'h40, 32'h0);
        drain();
        check("strobe_rdata", rd_seen, 32'hBBBBAA44);

        // Aliasing through ignored upper address bits.
        rd_seen = 32'h0;
        issue(1'b1, 4'hF, 32'h8000_0040, 32'hCAFEF00D);
        issue(1'b0, 4'h0, 32'h40, 32'h0);
        drain();
        check("alias_rdata", rd_seen, 32'hCAFEF00D);

        // Reset with two requests pending (LATENCY=4 responses would be in cycles 4, 5).
        sel = 1;
        drive(1'b1, 1'b1, 4'h0, 32'h0, 32'h0); step();
        step();
        idle(); resetn = 1'b0; step();
        resetn = 1'b1; step();
        check("midrst_addr_ok", {31'b0, addr_ok_v[1]}, 32'd1);
        check("midrst_cnt1", resp_cnt_v[1], 32'h0);
        check("midrst_cnt0", resp_cnt_v[0], 32'h0);
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_dok", {31'b0, data_ok_v[1]}, 32'd0);
            step();
        end

        // Full back-pressure, LATENCY=4, req held for cycles 0..6.
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
            ao[k] = addr_ok_v[1];
            dk[k] = data_ok_v[1];
            step();
        end
        idle();
        check("full_addr_ok_pattern", {25'b0, ao}, 32'h63);
        check("full_data_ok_pattern", {25'b0, dk}, 32'h30);
        drain();

        // LATENCY=1: preload, reset (memory persists), 8 back-to-back reads.
        sel = 2;
        for (int k = 0; k < 8; k++) begin
            issue(1'b1, 4'hF, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k));
        end
        drain();
        resetn = 1'b0; step();
        resetn = 1'b1; step();
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                check("sweep_addr_ok", {31'b0, addr_ok_v[2]}, 32'd1);
                drive(1'b1, 1'b0, 4'h0, 32'h100 + 32'(4 * k), 32'h0);
            end else begin
                idle();
            end
            if (k >= 1) begin
                check("sweep_dok", {31'b0, data_ok_v[2]}, 32'd1);
                check("sweep_rdata", rdata_v[2], 32'hA000_0000 + 32'(k - 1));
            end
            step();
        end
        check("sweep_dok_end", {31'b0, data_ok_v[2]}, 32'd0);
        check("sweep_cnt", resp_cnt_v[2], 32'd8);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
